// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath: data width and ALU opcodes.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b100;
  localparam logic [OP_W-1:0] OP_MUL = 3'b101;
  localparam logic [OP_W-1:0] OP_SLT = 3'b110;

  function automatic logic is_zero(input logic [DATA_W-1:0] value);
    return (value == '0);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU core: selects one of six operations and flags an all-zero result.
module alu_comb
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] input_a,
  input  logic [DATA_W-1:0] input_b,
  input  logic [OP_W-1:0]   operation,
  output logic [DATA_W-1:0] next_result,
  output logic              next_zero
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic [DATA_W-1:0]        mul_lo;
  logic                     lt_s;

  assign a_s = input_a;
  assign b_s = input_b;

  // Low half of the product is sign-agnostic, so one unsigned multiply serves both.
  assign mul_lo = input_a * input_b;
  assign lt_s   = (a_s < b_s);

  always_comb begin
    next_result = '0;
    case (operation)
      OP_AND:  next_result = input_a & input_b;
      OP_OR:   next_result = input_a | input_b;
      OP_ADD:  next_result = input_a + input_b;
      OP_SUB:  next_result = input_a - input_b;
      OP_MUL:  next_result = mul_lo;
      OP_SLT:  next_result = {{(DATA_W-1){1'b0}}, lt_s};
      default: next_result = '0;
    endcase
  end

  assign next_zero = is_zero(next_result);

endmodule

// File: rtl/mips_alu.sv
// Registered 32-bit ALU: one-cycle latency, result and zero flag captured together.
module mips_alu
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] input_a,
  input  logic [DATA_W-1:0] input_b,
  input  logic [OP_W-1:0]   operation,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag
);

  logic [DATA_W-1:0] result_p0;
  logic              zero_p0;

  alu_comb u_alu_comb (
    .input_a     (input_a),
    .input_b     (input_b),
    .operation   (operation),
    .next_result (result_p0),
    .next_zero   (zero_p0)
  );

  // Stage p0 -> output register
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      zero_flag <= 1'b1;
    end else begin
      result    <= result_p0;
      zero_flag <= zero_p0;
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Scoreboard bench for mips_alu: expectations queued at drive time, compared one edge later.
module tb_mips_alu;

  logic        clk;
  logic        rst;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic [2:0]  operation;
  logic [31:0] result;
  logic        zero_flag;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        zf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  mips_alu dut (
    .clk       (clk),
    .rst       (rst),
    .input_a   (input_a),
    .input_b   (input_b),
    .operation (operation),
    .result    (result),
    .zero_flag (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    logic [63:0] prod;
    case (op)
      3'b000: return a & b;
      3'b001: return a | b;
      3'b010: return a + b;
      3'b100: return a + (~b + 32'd1);
      3'b101: begin
        prod = {32'd0, a} * {32'd0, b};
        return prod[31:0];
      end
      3'b110: begin
        if (a[31] != b[31]) return {31'd0, a[31]};
        return {31'd0, (a < b)};
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input string tag, input logic r, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] op,
                       input logic [31:0] exp_res, input logic exp_zf);
    exp_t e;
    @(negedge clk);
    rst       = r;
    input_a   = a;
    input_b   = b;
    operation = op;
    e.tag = tag;
    e.res = exp_res;
    e.zf  = exp_zf;
    q.push_back(e);
  endtask

  // Monitor: compare the oldest expectation just after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check({e.tag, ".res"}, result, e.res);
      check({e.tag, ".zf"}, {31'd0, zero_flag}, {31'd0, e.zf});
    end
  end

  initial begin
    logic [31:0] ra, rb, rexp;
    logic [2:0]  rop;
    rst = 1'b1; input_a = 32'h1234; input_b = 32'h99; operation = 3'b010;

    drive("rst0", 1'b1, 32'hdead_beef, 32'h1, 3'b010, 32'd0, 1'b1);
    drive("rst1", 1'b1, 32'h5, 32'h7, 3'b001, 32'd0, 1'b1);

    drive("sw111", 1'b0, 32'd550, 32'd450, 3'b111, 32'h0,     1'b1);
    drive("sw011", 1'b0, 32'd550, 32'd450, 3'b011, 32'h0,     1'b1);
    drive("swand", 1'b0, 32'd550, 32'd450, 3'b000, 32'h2,     1'b0);
    drive("swor",  1'b0, 32'd550, 32'd450, 3'b001, 32'h3E6,   1'b0);
    drive("swadd", 1'b0, 32'd550, 32'd450, 3'b010, 32'h3E8,   1'b0);
    drive("swsub", 1'b0, 32'd550, 32'd450, 3'b100, 32'h64,    1'b0);
    drive("swmul", 1'b0, 32'd550, 32'd450, 3'b101, 32'h3C6CC, 1'b0);
    drive("swslt", 1'b0, 32'd550, 32'd450, 3'b110, 32'h0,     1'b1);

    drive("slt_pos", 1'b0, 32'd100,       32'd450,       3'b110, 32'd1, 1'b0);
    drive("slt_neg", 1'b0, 32'hFFFF_FFFF, 32'd1,         3'b110, 32'd1, 1'b0);
    drive("slt_mix", 1'b0, 32'd1,         32'hFFFF_FFFF, 3'b110, 32'd0, 1'b1);

    drive("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'd1,       3'b010, 32'd0,         1'b1);
    drive("sub_wrap", 1'b0, 32'd0,         32'd1,       3'b100, 32'hFFFF_FFFF, 1'b0);
    drive("mul_wrap", 1'b0, 32'h0001_0000, 32'h0001_0000, 3'b101, 32'd0,       1'b1);

    drive("sub_eq", 1'b0, 32'h1234_5678, 32'h1234_5678, 3'b100, 32'd0,         1'b1);
    drive("or_eq",  1'b0, 32'h1234_5678, 32'h1234_5678, 3'b001, 32'h1234_5678, 1'b0);

    drive("rst_pri", 1'b1, 32'd1, 32'd1, 3'b010, 32'd0, 1'b1);
    drive("post_rst", 1'b0, 32'd1, 32'd1, 3'b010, 32'd2, 1'b0);

    drive("mid_a", 1'b0, 32'd7, 32'd6, 3'b101, 32'd42, 1'b0);
    drive("mid_rst", 1'b1, 32'd7, 32'd6, 3'b101, 32'd0, 1'b1);
    drive("mid_b", 1'b0, 32'hF0F0_0000, 32'h0F0F_FFFF, 3'b001, 32'hFFFF_FFFF, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra   = $urandom;
      rb   = (i % 5 == 0) ? ra : $urandom;
      rop  = 3'($urandom_range(0, 7));
      rexp = model(ra, rb, rop);
      drive($sformatf("rnd%0d", i), 1'b0, ra, rb, rop, rexp, (rexp == 32'd0));
    end

    repeat (3) @(negedge clk);
    check("drain", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
